// File: rtl/pingpong_sched_pkg.sv
// Shared types and defaults for the ping-pong frame scheduler: buffer lifecycle
// states, engine tracker states and parameter defaults.
package pingpong_sched_pkg;

  localparam int unsigned ACK_TIMEOUT_DEFAULT = 16;
  localparam int unsigned CNT_W_DEFAULT       = 16;

  typedef enum logic [2:0] {
    BufFree      = 3'd0,
    BufWriting   = 3'd1,
    BufWritten   = 3'd2,
    BufFiltering = 3'd3,
    BufFiltered  = 3'd4,
    BufReading   = 3'd5
  } buf_state_t;

  typedef enum logic [1:0] {
    TrkIdle    = 2'd0,
    TrkStart   = 2'd1,
    TrkWaitAck = 2'd2,
    TrkBusy    = 2'd3
  } trk_state_t;

endpackage

// File: rtl/engine_tracker.sv
// Tracks one engine job: one-cycle start pulse, wait for the engine to leave idle,
// then report done when it returns to idle. A missing acknowledge times out as done.
module engine_tracker
  import pingpong_sched_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_issue,
  input  logic i_idle,
  output logic o_ready,
  output logic o_start,
  output logic o_done,
  output logic o_timeout
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  trk_state_t      r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= TrkIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_done      = 1'b0;
    o_timeout   = 1'b0;
    unique case (r_state)
      TrkIdle: begin
        if (i_issue) w_state_nxt = TrkStart;
      end
      TrkStart: begin
        w_state_nxt = TrkWaitAck;
        w_cnt_nxt   = '0;
      end
      TrkWaitAck: begin
        if (!i_idle) begin
          w_state_nxt = TrkBusy;
        end else if (r_cnt == CntW'(ACK_TIMEOUT - 1)) begin
          // Treat the missing acknowledge as a completed job so the pipeline keeps moving.
          o_timeout   = 1'b1;
          o_done      = 1'b1;
          w_state_nxt = TrkIdle;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      TrkBusy: begin
        if (i_idle) begin
          o_done      = 1'b1;
          w_state_nxt = TrkIdle;
        end
      end
      default: w_state_nxt = TrkIdle;
    endcase
  end

  assign o_ready = (r_state == TrkIdle);
  assign o_start = (r_state == TrkStart);

endmodule

// File: rtl/pingpong_frame_scheduler.sv
// Schedules writer, in-place filter and reader engines over two ping-pong buffers,
// keeping each buffer in exactly one lifecycle state and jobs in frame order.
module pingpong_frame_scheduler
  import pingpong_sched_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic             wr_start,
  output logic             wr_index,
  input  logic             wr_idle,
  output logic             flt_start,
  output logic             flt_index,
  input  logic             flt_idle,
  output logic             rd_start,
  output logic             rd_index,
  input  logic             rd_idle,
  output logic [1:0][2:0]  buf_state,
  output logic [CNT_W-1:0] frames_done,
  output logic             err_timeout
);

  logic w_wr_ready, w_flt_ready, w_rd_ready;
  logic w_wr_done, w_flt_done, w_rd_done;
  logic w_wr_to, w_flt_to, w_rd_to;
  logic w_wr_issue, w_flt_issue, w_rd_issue;
  logic w_flt_sel, w_flt_avail, w_rd_sel, w_rd_avail;

  buf_state_t       r_buf [2];
  buf_state_t       w_buf_nxt [2];
  logic             r_wr_next, r_flt_next, r_rd_next;
  logic             r_wr_index, r_flt_index, r_rd_index;
  logic [CNT_W-1:0] r_frames_done;
  logic             r_err;

  engine_tracker #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wr_trk (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_issue  (w_wr_issue),
    .i_idle   (wr_idle),
    .o_ready  (w_wr_ready),
    .o_start  (wr_start),
    .o_done   (w_wr_done),
    .o_timeout(w_wr_to)
  );

  engine_tracker #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_flt_trk (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_issue  (w_flt_issue),
    .i_idle   (flt_idle),
    .o_ready  (w_flt_ready),
    .o_start  (flt_start),
    .o_done   (w_flt_done),
    .o_timeout(w_flt_to)
  );

  engine_tracker #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_rd_trk (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_issue  (w_rd_issue),
    .i_idle   (rd_idle),
    .o_ready  (w_rd_ready),
    .o_start  (rd_start),
    .o_done   (w_rd_done),
    .o_timeout(w_rd_to)
  );

  // Each stage remembers which buffer is oldest; prefer it, fall back to the other.
  always_comb begin
    w_flt_sel   = r_flt_next;
    w_flt_avail = 1'b0;
    if (r_buf[r_flt_next] == BufWritten) begin
      w_flt_avail = 1'b1;
    end else if (r_buf[~r_flt_next] == BufWritten) begin
      w_flt_sel   = ~r_flt_next;
      w_flt_avail = 1'b1;
    end
    w_rd_sel   = r_rd_next;
    w_rd_avail = 1'b0;
    if (r_buf[r_rd_next] == BufFiltered) begin
      w_rd_avail = 1'b1;
    end else if (r_buf[~r_rd_next] == BufFiltered) begin
      w_rd_sel   = ~r_rd_next;
      w_rd_avail = 1'b1;
    end
  end

  assign w_wr_issue  = enable & w_wr_ready & wr_idle & (r_buf[r_wr_next] == BufFree);
  assign w_flt_issue = enable & w_flt_ready & flt_idle & w_flt_avail;
  assign w_rd_issue  = enable & w_rd_ready & rd_idle & w_rd_avail;

  // Completions are applied before issues; both never target the same buffer.
  always_comb begin
    w_buf_nxt = r_buf;
    if (w_wr_done)   w_buf_nxt[r_wr_index]  = BufWritten;
    if (w_flt_done)  w_buf_nxt[r_flt_index] = BufFiltered;
    if (w_rd_done)   w_buf_nxt[r_rd_index]  = BufFree;
    if (w_wr_issue)  w_buf_nxt[r_wr_next]   = BufWriting;
    if (w_flt_issue) w_buf_nxt[w_flt_sel]   = BufFiltering;
    if (w_rd_issue)  w_buf_nxt[w_rd_sel]    = BufReading;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf[0]      <= BufFree;
      r_buf[1]      <= BufFree;
      r_wr_next     <= 1'b0;
      r_flt_next    <= 1'b0;
      r_rd_next     <= 1'b0;
      r_wr_index    <= 1'b0;
      r_flt_index   <= 1'b0;
      r_rd_index    <= 1'b0;
      r_frames_done <= '0;
      r_err         <= 1'b0;
    end else begin
      r_buf <= w_buf_nxt;
      if (w_wr_issue) begin
        r_wr_index <= r_wr_next;
        r_wr_next  <= ~r_wr_next;
      end
      if (w_flt_issue) begin
        r_flt_index <= w_flt_sel;
        r_flt_next  <= ~w_flt_sel;
      end
      if (w_rd_issue) begin
        r_rd_index <= w_rd_sel;
        r_rd_next  <= ~w_rd_sel;
      end
      if (w_rd_done) r_frames_done <= r_frames_done + CNT_W'(1);
      if (w_wr_to | w_flt_to | w_rd_to) r_err <= 1'b1;
    end
  end

  assign buf_state[0] = r_buf[0];
  assign buf_state[1] = r_buf[1];
  assign wr_index     = r_wr_index;
  assign flt_index    = r_flt_index;
  assign rd_index     = r_rd_index;
  assign frames_done  = r_frames_done;
  assign err_timeout  = r_err;

endmodule

// File: tb/tb_pingpong_frame_scheduler.sv
// Bench for pingpong_frame_scheduler: a cycle-by-cycle vector table for the first
// frames, then engine models for steady state, stall, timeout and enable corners.
module tb_pingpong_frame_scheduler;
  import pingpong_sched_pkg::*;

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ACK_TO = 16;

  logic             clk = 1'b0;
  logic             reset_n, enable;
  logic             wr_start, wr_index, flt_start, flt_index, rd_start, rd_index;
  logic             wr_idle, flt_idle, rd_idle;
  logic [1:0][2:0]  buf_state;
  logic [CNT_W-1:0] frames_done;
  logic             err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Engine idle comes from the vector table (manual) or from the engine models.
  logic       auto_mode;
  logic [2:0] man_idle;
  logic [2:0] mdl_idle;
  int         mdl_cnt [3];
  int         dur [3];
  bit         mute [3];
  logic [2:0] starts;
  logic [2:0] idxs;

  always #5 clk = ~clk;

  assign wr_idle  = auto_mode ? mdl_idle[0] : man_idle[0];
  assign flt_idle = auto_mode ? mdl_idle[1] : man_idle[1];
  assign rd_idle  = auto_mode ? mdl_idle[2] : man_idle[2];
  assign starts   = {rd_start, flt_start, wr_start};
  assign idxs     = {rd_index, flt_index, wr_index};

  pingpong_frame_scheduler #(.ACK_TIMEOUT(ACK_TO), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .wr_start   (wr_start),
    .wr_index   (wr_index),
    .wr_idle    (wr_idle),
    .flt_start  (flt_start),
    .flt_index  (flt_index),
    .flt_idle   (flt_idle),
    .rd_start   (rd_start),
    .rd_index   (rd_index),
    .rd_idle    (rd_idle),
    .buf_state  (buf_state),
    .frames_done(frames_done),
    .err_timeout(err_timeout)
  );

  // Engine model: drops idle when it sees start, stays busy dur cycles (0 = random 5..50).
  always @(posedge clk) begin
    #1;
    for (int e = 0; e < 3; e++) begin
      if (!auto_mode) begin
        mdl_idle[e] = 1'b1;
        mdl_cnt[e]  = 0;
      end else if (mdl_cnt[e] > 0) begin
        mdl_cnt[e]--;
        if (mdl_cnt[e] == 0) mdl_idle[e] = 1'b1;
      end else if (starts[e] && !mute[e]) begin
        mdl_idle[e] = 1'b0;
        mdl_cnt[e]  = (dur[e] == 0) ? int'($urandom_range(50, 5)) : dur[e];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input int e, input int budget, input string name);
    int n = 0;
    while (!starts[e] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(starts[e]), 32'd1);
  endtask

  task automatic do_reset(input bit use_model);
    auto_mode = 1'b0;
    enable    = 1'b0;
    reset_n   = 1'b0;
    man_idle  = 3'b111;
    repeat (3) @(negedge clk);
    auto_mode = use_model;
    reset_n   = 1'b1;
    enable    = 1'b1;
  endtask

  typedef struct {
    logic [3:0]       in;   // {enable, wr_idle, flt_idle, rd_idle}
    logic [5:0]       ctl;  // {wr_start, wr_index, flt_start, flt_index, rd_start, rd_index}
    logic [2:0]       b0;
    logic [2:0]       b1;
    logic [CNT_W-1:0] fd;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int   rd_seen, overlap, cyc, n_extra, stall_wr, found;
    logic exp_rx;

    vecs[0]  = '{4'b1111, 6'b000000, 3'd0, 3'd0, 3'd0};
    vecs[1]  = '{4'b1111, 6'b100000, 3'd1, 3'd0, 3'd0};
    vecs[2]  = '{4'b1011, 6'b000000, 3'd1, 3'd0, 3'd0};
    vecs[3]  = '{4'b1011, 6'b000000, 3'd1, 3'd0, 3'd0};
    vecs[4]  = '{4'b1111, 6'b000000, 3'd1, 3'd0, 3'd0};
    vecs[5]  = '{4'b1111, 6'b000000, 3'd2, 3'd0, 3'd0};
    vecs[6]  = '{4'b1111, 6'b111000, 3'd3, 3'd1, 3'd0};
    vecs[7]  = '{4'b1001, 6'b010000, 3'd3, 3'd1, 3'd0};
    vecs[8]  = '{4'b1011, 6'b010000, 3'd3, 3'd1, 3'd0};
    vecs[9]  = '{4'b1011, 6'b010000, 3'd4, 3'd1, 3'd0};
    vecs[10] = '{4'b1111, 6'b010010, 3'd5, 3'd1, 3'd0};
    vecs[11] = '{4'b1110, 6'b010000, 3'd5, 3'd2, 3'd0};
    vecs[12] = '{4'b1111, 6'b011100, 3'd5, 3'd3, 3'd0};
    vecs[13] = '{4'b1101, 6'b010100, 3'd0, 3'd3, 3'd1};
    vecs[14] = '{4'b1111, 6'b100100, 3'd1, 3'd3, 3'd1};
    vecs[15] = '{4'b1111, 6'b000100, 3'd1, 3'd4, 3'd1};
    vecs[16] = '{4'b1111, 6'b000111, 3'd1, 3'd5, 3'd1};

    for (int e = 0; e < 3; e++) begin
      dur[e]  = 0;
      mute[e] = 1'b0;
    end

    // Vector table: one row per cycle, starting at reset release.
    do_reset(1'b0);
    for (int k = 0; k < 17; k++) begin
      check($sformatf("vec[%0d]", k),
            32'({wr_start, wr_index, flt_start, flt_index, rd_start, rd_index,
                 buf_state[0], buf_state[1], frames_done, err_timeout}),
            32'({vecs[k].ctl, vecs[k].b0, vecs[k].b1, vecs[k].fd, 1'b0}));
      enable   = vecs[k].in[3];
      man_idle = {vecs[k].in[0], vecs[k].in[1], vecs[k].in[2]};
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a read job.
    #2 reset_n = 1'b0;
    #1 check("async_reset",
             32'({starts, idxs, buf_state[0], buf_state[1], frames_done, err_timeout}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    found = 0;
    for (int i = 0; i < 4 && found == 0; i++) begin
      @(negedge clk);
      if (|starts) found = 1;
    end
    check("first_start_after_reset", 32'({found[0], starts, wr_index}), 32'({1'b1, 3'b001, 1'b0}));

    // Steady state with random engine durations; reader must alternate buffers.
    do_reset(1'b1);
    rd_seen = 0; overlap = 0; cyc = 0; exp_rx = 1'b0;
    while (rd_seen < 10 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      for (int a = 0; a < 3; a++)
        for (int b = a + 1; b < 3; b++)
          if (mdl_cnt[a] > 0 && mdl_cnt[b] > 0 && idxs[a] == idxs[b]) overlap++;
      if (rd_start) begin
        check($sformatf("rd_order[%0d]", rd_seen), 32'(rd_index), 32'(exp_rx));
        exp_rx = ~exp_rx;
        rd_seen++;
        if (rd_seen == 10) enable = 1'b0;
      end
    end
    check("steady_reads", 32'(rd_seen), 32'd10);
    repeat (100) begin
      @(negedge clk);
      for (int a = 0; a < 3; a++)
        for (int b = a + 1; b < 3; b++)
          if (mdl_cnt[a] > 0 && mdl_cnt[b] > 0 && idxs[a] == idxs[b]) overlap++;
    end
    check("frames_done_wrap", 32'(frames_done), 32'(10 % (1 << CNT_W)));
    check("no_shared_index", 32'(overlap), 32'd0);
    check("no_err_steady", 32'(err_timeout), 32'd0);

    // Reader stalled on buffer 0 while buffer 1 is filtered: writer must wait.
    dur[0] = 3; dur[1] = 3; dur[2] = 200;
    do_reset(1'b1);
    wait_start(2, 100, "stall_rd_start");
    check("stall_rd_index", 32'(rd_index), 32'd0);
    stall_wr = 0; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (wr_start) stall_wr++;
    end while (!rd_idle && cyc < 300);
    check("stall_rd_done", 32'(rd_idle), 32'd1);
    check("stall_no_wr_start", 32'(stall_wr), 32'd0);
    check("stall_buf1_filtered", 32'(buf_state[1]), 32'(BufFiltered));
    found = 0;
    repeat (2) begin
      @(negedge clk);
      if (wr_start && found == 0) begin
        found = 1;
        check("stall_wr_index", 32'(wr_index), 32'd0);
      end
    end
    check("stall_wr_after_done", 32'(found), 32'd1);

    // Filter never acknowledges: timeout after ACK_TO cycles waiting.
    dur[0] = 3; dur[1] = 3; dur[2] = 3; mute[1] = 1'b1;
    do_reset(1'b1);
    wait_start(1, 100, "to_flt_start");
    repeat (ACK_TO) @(negedge clk);
    check("err_before_timeout", 32'(err_timeout), 32'd0);
    @(negedge clk);
    check("err_on_timeout", 32'({err_timeout, buf_state[0]}), 32'({1'b1, BufFiltered}));
    @(negedge clk);
    check("rd_after_timeout", 32'({rd_start, rd_index}), 32'b10);
    repeat (40) @(negedge clk);
    check("err_sticky", 32'(err_timeout), 32'd1);
    mute[1] = 1'b0;

    // Enable dropped during filter job: job finishes, nothing new starts.
    dur[0] = 3; dur[1] = 10; dur[2] = 3;
    do_reset(1'b1);
    wait_start(1, 100, "en_flt_start");
    enable  = 1'b0;
    n_extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (|starts) n_extra++;
    end
    check("en_off_no_starts", 32'(n_extra), 32'd0);
    check("en_off_bufs", 32'({buf_state[0], buf_state[1]}), 32'({BufFiltered, BufWritten}));
    enable = 1'b1;
    @(negedge clk);
    check("en_on_rd_start", 32'({rd_start, rd_index}), 32'b10);
    check("en_on_flt_start", 32'({flt_start, flt_index}), 32'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

endmodule
